// File: rtl/apb_req_master.sv
// apb_req_master: turns a valid/ready request stream into single APB4
// SETUP/ACCESS transfers and returns the result on a valid/ready response.
// Optional ACCESS timeout is compiled in with `define APB_MASTER_TIMEOUT_EN.
module apb_req_master #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 11,
  parameter int TIMEOUT    = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic                    req_prot,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_strb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic [ADDR_WIDTH-1:0]   paddr,
  output logic                    pprot,
  output logic                    psel,
  output logic                    penable,
  output logic                    pwrite,
  output logic [DATA_WIDTH-1:0]   pwdata,
  output logic [DATA_WIDTH/8-1:0] pstrb,
  input  logic                    pready,
  input  logic [DATA_WIDTH-1:0]   prdata,
  input  logic                    pslverr
);

  if (TIMEOUT < 1) begin : g_timeout_range
    $error("apb_req_master: TIMEOUT must be >= 1");
  end

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t state, state_nxt;
  logic   accept, done, abort;

  assign accept = (state == IDLE) && req_valid && req_ready;
  assign done   = (state == ACCESS) && pready;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 5) ? $clog2(TIMEOUT + 1) : 5;
  logic [CNT_W-1:0] to_cnt;

  // Count ACCESS cycles that ended without pready; cleared while in SETUP.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                        to_cnt <= '0;
    else if (state == SETUP)             to_cnt <= '0;
    else if (state == ACCESS && !pready) to_cnt <= to_cnt + 1'b1;
  end

  // Abort on the TIMEOUT-th ACCESS cycle if the slave still has not answered.
  assign abort = (state == ACCESS) && !pready && (to_cnt == CNT_W'(TIMEOUT - 1));
`else
  assign abort = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic: one transfer at a time, IDLE->SETUP->ACCESS->RESP.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)        state_nxt = SETUP;
      SETUP:                      state_nxt = ACCESS;
      ACCESS:  if (done || abort) state_nxt = RESP;
      RESP:    if (rsp_ready)     state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  // Registered outputs; APB fields are loaded straight from the request at
  // accept and then held for the whole transfer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      paddr     <= '0;
      pprot     <= 1'b0;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      pwdata    <= '0;
      pstrb     <= '0;
    end else begin
      req_ready <= (state_nxt == IDLE);
      if (accept) begin
        paddr   <= req_addr;
        pprot   <= req_prot;
        pwrite  <= req_write;
        pwdata  <= req_wdata;
        pstrb   <= req_write ? req_strb : '0;
        psel    <= 1'b1;
        penable <= 1'b0;
      end
      if (state == SETUP) penable <= 1'b1;
      if (done || abort) begin
        psel      <= 1'b0;
        penable   <= 1'b0;
        rsp_valid <= 1'b1;
        rsp_rdata <= (pwrite || abort) ? '0 : prdata;
        // pslverr only means something alongside pready; a timeout is an error.
        rsp_err   <= done ? pslverr : 1'b1;
      end
      if (state == RESP && rsp_ready) rsp_valid <= 1'b0;
    end
  end

endmodule
